iic_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one IIC_Driver instance between three requesters, for example the OLED command stream, a sensor register reader and a configuration loader. Each requester presents a 24-bit command word and a read/write flag. The arbiter grants one requester at a time, drives the driver's request/slave/data inputs, waits for completion, and returns a done or error pulse. It sits between the requester blocks and the IIC_Driver, replacing direct per-requester driver instances.

---
 rtl/iic_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_iic_bus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one IIC driver between three requesters.
// Grants one command at a time, waits for the matching completion or a timeout, then idles the bus.
module iic_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rd,
  input  logic [71:0] req_cmd,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic [7:0]  rdata,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        iic_write_req,
  output logic        iic_read_req,
  output logic [15:0] iic_slave,
  output logic [7:0]  iic_wdata,
  input  logic        iic_write_done,
  input  logic        iic_read_done,
  input  logic [7:0]  iic_rdata
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      win_q, win_d;
  logic            rd_q, rd_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      done_q, done_d;
  logic [2:0]      err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            wr_req_q, wr_req_d;
  logic            rd_req_q, rd_req_d;
  logic [15:0]     slave_q, slave_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            busy_q, busy_d;

  logic            arb_found;
  logic [1:0]      arb_idx;
  logic [1:0]      cand;
  logic [23:0]     sel_cmd;
  logic            cmpl;
  logic            tmo_hit;

  // Modulo-3 add; operands never exceed 2.
  function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

  // Scan from farthest to nearest so the first requester at or after ptr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap_add(ptr_q, 2'(k));
      if (req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    case (arb_idx)
      2'd1:    sel_cmd = req_cmd[47:24];
      2'd2:    sel_cmd = req_cmd[71:48];
      default: sel_cmd = req_cmd[23:0];
    endcase
  end

  // Only the done pulse of the operation in flight counts.
  assign cmpl    = rd_q ? iic_read_done : iic_write_done;
  assign tmo_hit = (tmo_cnt_q == TmoLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    rd_d      = rd_q;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;
    grant_d   = grant_q;
    done_d    = 3'b000;
    err_d     = 3'b000;
    rdata_d   = rdata_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    slave_d   = slave_q;
    wdata_d   = wdata_q;

    case (state_q)
      StIdle: begin
        if (arb_found) begin
          win_d     = arb_idx;
          rd_d      = req_rd[arb_idx];
          slave_d   = {sel_cmd[15:8], sel_cmd[23:16]};
          wdata_d   = sel_cmd[7:0];
          grant_d   = 3'b001 << arb_idx;
          wr_req_d  = ~req_rd[arb_idx];
          rd_req_d  = req_rd[arb_idx];
          ptr_d     = wrap_add(arb_idx, 2'd1);
          tmo_cnt_d = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (cmpl || tmo_hit) begin
          wr_req_d  = 1'b0;
          rd_req_d  = 1'b0;
          grant_d   = 3'b000;
          gap_cnt_d = '0;
          if (cmpl) begin
            done_d = 3'b001 << win_q;
            if (rd_q) begin
              rdata_d = iic_rdata;
            end
          end else begin
            err_d = 3'b001 << win_q;
          end
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      rd_q      <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      grant_q   <= 3'b000;
      done_q    <= 3'b000;
      err_q     <= 3'b000;
      rdata_q   <= 8'h00;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      slave_q   <= 16'h0000;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      rd_q      <= rd_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      slave_q   <= slave_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign grant         = grant_q;
  assign busy          = busy_q;
  assign iic_write_req = wr_req_q;
  assign iic_read_req  = rd_req_q;
  assign iic_slave     = slave_q;
  assign iic_wdata     = wdata_q;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed bench for iic_bus_arbiter: expected done/err/rdata events are queued when
// stimulus is applied and compared when the arbiter pulses.
module tb_iic_bus_arbiter;

  localparam int unsigned Tmo = 64;
  localparam int unsigned Gap = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_rd;
  logic [71:0] req_cmd;
  logic [2:0]  done, err, grant;
  logic [7:0]  rdata, iic_wdata, iic_rdata;
  logic        busy, iic_write_req, iic_read_req, iic_write_done, iic_read_done;
  logic [15:0] iic_slave;

  iic_bus_arbiter #(
    .TIMEOUT_CYCLES (Tmo),
    .GAP_CYCLES     (Gap)
  ) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_rd         (req_rd),
    .req_cmd        (req_cmd),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .grant          (grant),
    .busy           (busy),
    .iic_write_req  (iic_write_req),
    .iic_read_req   (iic_read_req),
    .iic_slave      (iic_slave),
    .iic_wdata      (iic_wdata),
    .iic_write_done (iic_write_done),
    .iic_read_done  (iic_read_done),
    .iic_rdata      (iic_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [2:0] done;
    logic [2:0] err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic [2:0] e, input logic [7:0] r);
    exp_t x;
    x.done  = d;
    x.err   = e;
    x.rdata = r;
    sb.push_back(x);
  endtask

  task automatic wait_grant(input string tag, input logic [2:0] exp, input int budget,
                            output int waited);
    waited = 0;
    while (grant == 3'b000 && waited < budget) begin
      tick(1);
      waited++;
    end
    checks++;
    assert (grant != 3'b000) else begin
      errors++;
      $error("FAIL %s: no grant within %0d cycles, observed=%0h expected=%0h",
             tag, budget, grant, exp);
    end
    if (grant != 3'b000) check(tag, grant, exp);
  endtask

  // Waits for a done/err pulse and compares it with the oldest queued expectation.
  task automatic wait_event(input string tag, input int budget, output int waited);
    exp_t x;
    waited = 0;
    while ((done | err) == 3'b000 && waited < budget) begin
      tick(1);
      waited++;
    end
    checks++;
    assert ((done | err) != 3'b000) else begin
      errors++;
      $error("FAIL %s: no done/err within %0d cycles, observed=0 expected=pulse", tag, budget);
    end
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=queued entry", tag);
    end
    if ((done | err) != 3'b000 && sb.size() != 0) begin
      x = sb.pop_front();
      check({tag, "_done"}, done, x.done);
      check({tag, "_err"}, err, x.err);
      check({tag, "_rdata"}, rdata, x.rdata);
      check({tag, "_grant_clr"}, grant, 3'b000);
      check({tag, "_req_clr"}, {iic_write_req, iic_read_req}, 2'b00);
    end
  endtask

  task automatic pulse_wr();
    iic_write_done = 1'b1;
    tick(1);
    iic_write_done = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    iic_rdata     = d;
    iic_read_done = 1'b1;
    tick(1);
    iic_read_done = 1'b0;
    iic_rdata     = 8'hFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int w;
    int hi;
    rst_n = 1'b0;
    req = 3'b000;
    req_rd = 3'b000;
    req_cmd = '0;
    iic_write_done = 1'b0;
    iic_read_done = 1'b0;
    iic_rdata = 8'h00;
    tick(2);
    check("rst_grant", grant, 3'b000);
    check("rst_done_err", {done, err}, 6'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_iic_req", {iic_write_req, iic_read_req}, 2'b00);
    check("rst_slave_wdata", {iic_slave, iic_wdata}, 24'h0);
    rst_n = 1'b1;
    tick(1);

    // Single write, driver completes after 50 cycles of request.
    req_cmd[47:24] = 24'h7800AE;
    req[1] = 1'b1;
    push(3'b010, 3'b000, 8'h00);
    wait_grant("t1_grant", 3'b010, 10, w);
    check("t1_latency", w, 1);
    check("t1_slave", iic_slave, 16'h0078);
    check("t1_wdata", iic_wdata, 8'hAE);
    check("t1_iic_req", {iic_write_req, iic_read_req}, 2'b10);
    check("t1_busy", busy, 1'b1);
    hi = iic_write_req ? 1 : 0;
    for (int k = 0; k < 49; k++) begin
      tick(1);
      if (iic_write_req) hi++;
    end
    pulse_wr();
    check("t1_wreq_cycles", hi, 50);
    wait_event("t1", 5, w);
    req[1] = 1'b0;
    tick(1);
    check("t1_done_width", done, 3'b000);
    check("t1_busy_gap", busy, 1'b1);

    // Read path; a stray write-done is ignored.
    req_cmd[71:48] = 24'hB80200;
    req_rd[2] = 1'b1;
    req[2] = 1'b1;
    push(3'b100, 3'b000, 8'h5A);
    wait_grant("t2_grant", 3'b100, 20, w);
    check("t2_gap", w + 1, Gap + 1);
    check("t2_slave", iic_slave, 16'h02B8);
    check("t2_iic_req", {iic_write_req, iic_read_req}, 2'b01);
    tick(3);
    pulse_wr();
    check("t2_ignore_done", done, 3'b000);
    check("t2_ignore_grant", grant, 3'b100);
    tick(2);
    pulse_rd(8'h5A);
    wait_event("t2", 5, w);
    req[2] = 1'b0;
    tick(1);
    check("t2_done_width", done, 3'b000);
    check("t2_rdata_hold", rdata, 8'h5A);

    // Later write keeps rdata; a stray read-done is ignored.
    req_rd[2] = 1'b0;
    req_cmd[71:48] = 24'h3C1055;
    req[2] = 1'b1;
    push(3'b100, 3'b000, 8'h5A);
    wait_grant("t2b_grant", 3'b100, 20, w);
    check("t2b_wdata", iic_wdata, 8'h55);
    check("t2b_iic_req", {iic_write_req, iic_read_req}, 2'b10);
    tick(2);
    pulse_rd(8'h77);
    check("t2b_ignore_done", done, 3'b000);
    check("t2b_ignore_rdata", rdata, 8'h5A);
    tick(1);
    pulse_wr();
    wait_event("t2b", 5, w);
    req[2] = 1'b0;
    tick(1);

    // Contention: all three requesting, served 0,1,2.
    req_cmd = {24'h122232, 24'h112131, 24'h102030};
    req = 3'b111;
    push(3'b001, 3'b000, 8'h5A);
    push(3'b010, 3'b000, 8'h5A);
    push(3'b100, 3'b000, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      wait_grant("t3_grant", 3'b001 << i, 20, w);
      if (i > 0) check("t3_gap", w + 1, Gap + 1);
      check("t3_wdata", iic_wdata, 32'h30 + i);
      tick(2);
      pulse_wr();
      wait_event("t3", 5, w);
      req[i] = 1'b0;
      tick(1);
      check("t3_done_width", done, 3'b000);
    end

    // Rotation: req[0] held, req[2] raised while 0 is granted.
    req_cmd[23:0] = 24'h200111;
    req_cmd[71:48] = 24'h200222;
    req = 3'b001;
    push(3'b001, 3'b000, 8'h5A);
    wait_grant("t4_grant0", 3'b001, 20, w);
    tick(1);
    req[2] = 1'b1;
    push(3'b100, 3'b000, 8'h5A);
    tick(2);
    pulse_wr();
    wait_event("t4a", 5, w);
    tick(1);
    wait_grant("t4_grant2", 3'b100, 20, w);
    check("t4_gap", w + 1, Gap + 1);
    tick(2);
    pulse_wr();
    wait_event("t4b", 5, w);
    req[2] = 1'b0;
    tick(1);

    // Timeout on requester 0: driver stays silent.
    push(3'b000, 3'b001, 8'h5A);
    wait_grant("t4_grant0b", 3'b001, 20, w);
    wait_event("t4_tmo", Tmo + 10, w);
    check("t4_tmo_cycles", w, Tmo);
    tick(1);
    check("t4_err_width", err, 3'b000);
    push(3'b001, 3'b000, 8'h5A);
    wait_grant("t4_grant_after", 3'b001, 20, w);
    check("t4_gap_after", w + 1, Gap + 1);
    tick(1);
    pulse_wr();
    wait_event("t4c", 5, w);
    req[0] = 1'b0;
    tick(1);

    // Reset while a write is in flight.
    req_cmd[23:0] = 24'h400111;
    req_cmd[47:24] = 24'h400222;
    req = 3'b011;
    wait_grant("t5_grant_pre", 3'b010, 20, w);
    check("t5_wreq_pre", iic_write_req, 1'b1);
    tick(3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", grant, 3'b000);
    check("t5_rst_iic_req", {iic_write_req, iic_read_req}, 2'b00);
    check("t5_rst_pulses", {done, err}, 6'b0);
    check("t5_rst_rdata", rdata, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    tick(2);
    check("t5_rst_quiet", {done, err}, 6'b0);
    rst_n = 1'b1;
    push(3'b001, 3'b000, 8'h00);
    wait_grant("t5_grant0", 3'b001, 5, w);
    check("t5_latency", w, 1);
    tick(2);
    pulse_wr();
    wait_event("t5a", 5, w);
    req[0] = 1'b0;
    push(3'b010, 3'b000, 8'h00);
    tick(1);
    wait_grant("t5_grant1", 3'b010, 20, w);
    tick(2);
    pulse_wr();
    wait_event("t5b", 5, w);
    req[1] = 1'b0;
    tick(1);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
